// File: rtl/udma_l2_ro_arbiter_if.sv
// L2 read-only port bundle between the uDMA read arbiter (master) and the L2 interconnect (slave).
interface udma_l2_ro_arbiter_if #(
    parameter int L2_DATA_WIDTH = 32
);
    logic                         L2_ro_req_o;
    logic                         L2_ro_gnt_i;
    logic [31:0]                  L2_ro_addr_o;
    logic                         L2_ro_wen_o;
    logic [L2_DATA_WIDTH/8-1:0]   L2_ro_be_o;
    logic [L2_DATA_WIDTH-1:0]     L2_ro_wdata_o;
    logic                         L2_ro_rvalid_i;
    logic [L2_DATA_WIDTH-1:0]     L2_ro_rdata_i;

    modport master (
        output L2_ro_req_o, L2_ro_addr_o, L2_ro_wen_o, L2_ro_be_o, L2_ro_wdata_o,
        input  L2_ro_gnt_i, L2_ro_rvalid_i, L2_ro_rdata_i
    );

    modport slave (
        input  L2_ro_req_o, L2_ro_addr_o, L2_ro_wen_o, L2_ro_be_o, L2_ro_wdata_o,
        output L2_ro_gnt_i, L2_ro_rvalid_i, L2_ro_rdata_i
    );
endinterface

// File: rtl/udma_l2_ro_arbiter.sv
// Round-robin arbiter sharing the uDMA L2 read-only port; an ID FIFO routes in-order responses back.
// Optional performance counters are enabled by defining UDMA_L2_ARB_PERF_EN.
module udma_l2_ro_arbiter #(
    parameter int N_REQ           = 4,
    parameter int L2_DATA_WIDTH   = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_ni,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ-1:0][31:0]        addr_i,
    output logic [N_REQ-1:0]              gnt_o,
    output logic [N_REQ-1:0]              rvalid_o,
    output logic [L2_DATA_WIDTH-1:0]      rdata_o,
    udma_l2_ro_arbiter_if.master          l2_ro,
`ifdef UDMA_L2_ARB_PERF_EN
    input  logic                          perf_clr_i,
    output logic [31:0]                   perf_gnt_o,
    output logic [31:0]                   perf_stall_o,
`endif
    output logic                          err_o
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int FAW = $clog2(MAX_OUTSTANDING);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] locked_id_q, locked_id_d;
    logic           lock_q, lock_d;
    logic           err_q, err_d;
    logic [FAW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [IDW-1:0] fifo_mem_q [MAX_OUTSTANDING];
    logic [IDW-1:0] fifo_mem_d [MAX_OUTSTANDING];

    logic [IDW-1:0] sel;
    logic [IDW-1:0] head;
    logic           fifo_full, fifo_empty;
    logic           l2_req, hs, pop;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[FAW] != rptr_q[FAW]) && (wptr_q[FAW-1:0] == rptr_q[FAW-1:0]);
    assign head       = fifo_mem_q[rptr_q[FAW-1:0]];

    // A stalled request stays locked so the address toward L2 cannot change before grant.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        sel   = rr_ptr_q;
        if (lock_q) begin
            sel = locked_id_q;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % N_REQ;
                if (!found && req_i[idx]) begin
                    sel   = idx[IDW-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    assign l2_req = req_i[sel] & ~fifo_full;
    assign hs     = l2_req & l2_ro.L2_ro_gnt_i;
    assign pop    = l2_ro.L2_ro_rvalid_i & ~fifo_empty;

    assign l2_ro.L2_ro_req_o   = l2_req;
    assign l2_ro.L2_ro_addr_o  = addr_i[sel];
    assign l2_ro.L2_ro_wen_o   = 1'b1;
    assign l2_ro.L2_ro_be_o    = '1;
    assign l2_ro.L2_ro_wdata_o = '0;
    assign rdata_o             = l2_ro.L2_ro_rdata_i;
    assign err_o               = err_q;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_route
        assign gnt_o[gi]    = hs  && (sel  == IDW'(gi));
        assign rvalid_o[gi] = pop && (head == IDW'(gi));
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        err_d       = err_q;
        fifo_mem_d  = fifo_mem_q;

        if (hs) begin
            fifo_mem_d[wptr_q[FAW-1:0]] = sel;
            wptr_d                      = wptr_q + 1'b1;
            rr_ptr_d                    = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
            lock_d                      = 1'b0;
        end else if (l2_req) begin
            lock_d      = 1'b1;
            locked_id_d = sel;
        end else if (lock_q && !req_i[locked_id_q]) begin
            lock_d = 1'b0;
        end

        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end else if (l2_ro.L2_ro_rvalid_i) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            rr_ptr_q    <= '0;
            locked_id_q <= '0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            locked_id_q <= locked_id_d;
            lock_q      <= lock_d;
            err_q       <= err_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fifo_mem_q  <= fifo_mem_d;
        end
    end

`ifdef UDMA_L2_ARB_PERF_EN
    logic [31:0] perf_gnt_q, perf_gnt_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Clear takes priority over a same-cycle increment; both counters saturate.
    always_comb begin
        perf_gnt_d   = perf_gnt_q;
        perf_stall_d = perf_stall_q;
        if (perf_clr_i) begin
            perf_gnt_d   = '0;
            perf_stall_d = '0;
        end else begin
            if (hs && perf_gnt_q != 32'hFFFF_FFFF) begin
                perf_gnt_d = perf_gnt_q + 32'd1;
            end
            if ((|req_i) && !hs && perf_stall_q != 32'hFFFF_FFFF) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            perf_gnt_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_gnt_q   <= perf_gnt_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_gnt_o   = perf_gnt_q;
    assign perf_stall_o = perf_stall_q;
`endif
endmodule
